serial_add_sub: RTL and testbench

Bit-serial two's-complement adder/subtractor. It accepts a WIDTH-bit operand pair through a valid/ready handshake and pushes one bit per cycle, LSB first, through a single full-adder cell and a carry flip-flop. It reassembles the sum word in a shift register and presents the result through a second valid/ready handshake. It is the sequential, area-minimal counterpart of the combinational full-adder netlists used in the gate-level flow, and serves as a sequential benchmark for the extraction tooling.

---
 rtl/serial_add_sub_pkg.sv | 14 +
 rtl/serial_add_sub_if.sv | 25 ++
 rtl/serial_add_sub_fa_cell.sv | 26 ++
 rtl/serial_add_sub.sv | 90 +++++++++
 tb/tb_serial_add_sub.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_sub_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_sub_if.sv
// Operand and result handshakes of serial_add_sub bundled as one interface.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/serial_add_sub_fa_cell.sv
// One-bit full adder built only from AND2 and inverters so it maps
// directly onto the gate-level cell library.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic ab_n, ba_n, axb;
    logic xc_n, cx_n;
    logic g_n, p_n;

    assign ab_n = ~(a & ~b);
    assign ba_n = ~(~a & b);
    assign axb  = ~(ab_n & ba_n);

    assign xc_n = ~(axb & ~ci);
    assign cx_n = ~(~axb & ci);
    assign s    = ~(xc_n & cx_n);

    // co = ab | ci(a^b), as a NAND of the two inverted product terms
    assign g_n  = ~(a & b);
    assign p_n  = ~(ci & axb);
    assign co   = ~(g_n & p_n);
endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder cell, a carry
// flop and three shift registers, processing WIDTH bits LSB first.
module serial_add_sub
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_add_sub_if.slave bus
);
    localparam int CW = cnt_w(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh_a, sh_b, res;
    logic             carry, c_msb;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_co;
    logic             load, step, last_bit;

    fa_cell u_fa (
        .a  (sh_a[0]),
        .b  (sh_b[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Handshake outputs are gated by rst_n so they read 0 for the whole reset.
    always_comb begin
        state_nxt     = state;
        load          = 1'b0;
        step          = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = rst_n;
                if (bus.in_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = rst_n;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_a  <= '0;
            sh_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            c_msb <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            // Subtraction is a + ~b + 1: the +1 enters through the carry flop.
            sh_a  <= bus.a;
            sh_b  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub;
            cnt   <= '0;
        end else if (step) begin
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            res   <= {fa_s, res[WIDTH-1:1]};
            carry <= fa_co;
            cnt   <= cnt + CW'(1);
            if (last_bit) c_msb <= carry;
        end
    end

    assign bus.sum      = res;
    assign bus.cout     = carry;
    assign bus.overflow = c_msb ^ carry;
endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub at WIDTH 2, 8 and 16: directed vectors, backpressure,
// mid-run reset and randomised back-to-back traffic against an arithmetic model.
module tb_serial_add_sub;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc  = 0;
    int   nerr = 0;
    int   nchk = 0;
    int   wid[3] = '{2, 8, 16};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_add_sub_if #(.WIDTH(2))  if2 ();
    serial_add_sub_if #(.WIDTH(8))  if8 ();
    serial_add_sub_if #(.WIDTH(16)) if16 ();

    serial_add_sub #(.WIDTH(2))  u_w2  (.clk(clk), .rst_n(rst_n), .bus(if2));
    serial_add_sub #(.WIDTH(8))  u_w8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_add_sub #(.WIDTH(16)) u_w16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    // Width-agnostic views of the three instances, indexed 0/1/2.
    logic        iv[3], gsub[3], gor[3];
    logic [63:0] ga[3], gb[3];
    logic        ir[3], ovl[3], gc[3], go[3];
    logic [63:0] gs[3];

    assign if2.in_valid  = iv[0];   assign if2.a  = ga[0][1:0];  assign if2.b  = gb[0][1:0];
    assign if2.sub       = gsub[0]; assign if2.out_ready  = gor[0];
    assign if8.in_valid  = iv[1];   assign if8.a  = ga[1][7:0];  assign if8.b  = gb[1][7:0];
    assign if8.sub       = gsub[1]; assign if8.out_ready  = gor[1];
    assign if16.in_valid = iv[2];   assign if16.a = ga[2][15:0]; assign if16.b = gb[2][15:0];
    assign if16.sub      = gsub[2]; assign if16.out_ready = gor[2];

    assign ir[0] = if2.in_ready;  assign ovl[0] = if2.out_valid;  assign gs[0] = 64'(if2.sum);
    assign gc[0] = if2.cout;      assign go[0]  = if2.overflow;
    assign ir[1] = if8.in_ready;  assign ovl[1] = if8.out_valid;  assign gs[1] = 64'(if8.sum);
    assign gc[1] = if8.cout;      assign go[1]  = if8.overflow;
    assign ir[2] = if16.in_ready; assign ovl[2] = if16.out_valid; assign gs[2] = 64'(if16.sum);
    assign gc[2] = if16.cout;     assign go[2]  = if16.overflow;

    typedef struct {
        logic [7:0] a, b;
        bit         sub;
        logic [7:0] s;
        bit         c, o;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed readings.
    task automatic ref_op(input int w, input longint ua, input longint ub, input bit s,
                          output logic [63:0] es, output bit ec, output bit eo);
        longint m  = longint'(1) << w;
        longint sa = (ua >= m / 2) ? ua - m : ua;
        longint sb = (ub >= m / 2) ? ub - m : ub;
        longint r  = s ? sa - sb : sa + sb;
        longint u  = s ? ua - ub : ua + ub;
        eo = (r < -(m / 2)) || (r >= m / 2);
        ec = s ? (ua >= ub) : (ua + ub >= m);
        es = 64'(((u % m) + m) % m);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int i = 0; i < 3; i++) begin
                nchk++;
                if (ir[i] && ovl[i]) begin
                    nerr++;
                    $display("FAIL ready_valid_excl w%0d: in_ready=%0b out_valid=%0b, required not both 1",
                             wid[i], ir[i], ovl[i]);
                end
            end
        end
    end

    // Runs one operation on instance i; stall>0 holds out_ready low that many
    // cycles after out_valid. Called #1 after a rising edge.
    task automatic run_op(input int i, input logic [63:0] av, input logic [63:0] bv, input bit s,
                          input int stall, output logic [63:0] rs, output bit rc, output bit ro,
                          output int acc, output bit ok);
        int n = 0;
        logic [63:0] hs;
        bit hc, ho;
        ok = 1'b0; rs = '0; rc = 1'b0; ro = 1'b0; acc = 0;
        ga[i] = av; gb[i] = bv; gsub[i] = s; iv[i] = 1'b1; gor[i] = (stall == 0);
        while (!ir[i] && n < 50) begin @(posedge clk); #1; n++; end
        if (!ir[i]) begin
            iv[i] = 1'b0; nchk++; nerr++;
            $display("FAIL accept_timeout w%0d: in_ready stayed 0, required 1", wid[i]);
            return;
        end
        @(posedge clk); #1;
        acc = cyc;
        iv[i] = 1'b0;
        ga[i] = {$urandom, $urandom}; gb[i] = {$urandom, $urandom}; gsub[i] = $urandom_range(0, 1);
        n = 0;
        while (!ovl[i] && n < wid[i] + 10) begin @(posedge clk); #1; n++; end
        if (!ovl[i]) begin
            nchk++; nerr++;
            $display("FAIL result_timeout w%0d: out_valid stayed 0, required 1", wid[i]);
            return;
        end
        check($sformatf("latency w%0d", wid[i]), 64'(cyc - acc), 64'(wid[i]));
        if (stall > 0) begin
            hs = gs[i]; hc = gc[i]; ho = go[i];
            for (int k = 0; k < stall; k++) begin
                iv[i] = $urandom_range(0, 1);
                @(posedge clk); #1;
                check("stall_valid", 64'(ovl[i]), 64'(1));
                check("stall_ready", 64'(ir[i]), 64'(0));
                check("stall_sum", gs[i], hs);
                check("stall_cout_ovf", {62'd0, gc[i], go[i]}, {62'd0, hc, ho});
            end
            iv[i] = 1'b0;
            gor[i] = 1'b1;
        end
        rs = gs[i]; rc = gc[i]; ro = go[i];
        @(posedge clk); #1;
        check($sformatf("post_hs_valid w%0d", wid[i]), 64'(ovl[i]), 64'(0));
        check($sformatf("post_hs_ready w%0d", wid[i]), 64'(ir[i]), 64'(1));
        ok = 1'b1;
    endtask

    task automatic rand_run(input int i, input int nops);
        int prev_acc = 0, prev_stall = 1, stall, acc;
        logic [63:0] mask = (64'd1 << wid[i]) - 64'd1;
        logic [63:0] av, bv, es, rs;
        bit s, ec, eo, rc, ro, ok;
        for (int k = 0; k < nops; k++) begin
            av = {$urandom, $urandom} & mask;
            bv = {$urandom, $urandom} & mask;
            s  = $urandom_range(0, 1);
            stall = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            ref_op(wid[i], longint'(av), longint'(bv), s, es, ec, eo);
            run_op(i, av, bv, s, stall, rs, rc, ro, acc, ok);
            if (!ok) return;
            check($sformatf("rand_sum w%0d a=%0h b=%0h sub=%0b", wid[i], av, bv, s), rs, es);
            check($sformatf("rand_cout_ovf w%0d a=%0h b=%0h sub=%0b", wid[i], av, bv, s),
                  {62'd0, rc, ro}, {62'd0, ec, eo});
            if (prev_stall == 0)
                check($sformatf("period w%0d", wid[i]), 64'(acc - prev_acc), 64'(wid[i] + 2));
            prev_acc = acc; prev_stall = stall;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tv[6];
        logic [63:0] rs;
        bit          rc, ro, ok, seen;
        int          acc;

        tv[0] = '{a: 8'h5A, b: 8'h3C, sub: 1'b0, s: 8'h96, c: 1'b0, o: 1'b1};
        tv[1] = '{a: 8'h10, b: 8'h20, sub: 1'b1, s: 8'hF0, c: 1'b0, o: 1'b0};
        tv[2] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, s: 8'h00, c: 1'b1, o: 1'b0};
        tv[3] = '{a: 8'h80, b: 8'h01, sub: 1'b1, s: 8'h7F, c: 1'b1, o: 1'b1};
        tv[4] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, s: 8'h80, c: 1'b0, o: 1'b1};
        tv[5] = '{a: 8'h00, b: 8'h00, sub: 1'b1, s: 8'h00, c: 1'b1, o: 1'b0};

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; gor[i] = 1'b0; gsub[i] = 1'b0; ga[i] = '0; gb[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_ready w%0d", wid[i]), 64'(ir[i]), 64'(0));
            check($sformatf("rst_valid w%0d", wid[i]), 64'(ovl[i]), 64'(0));
            check($sformatf("rst_sum w%0d", wid[i]), gs[i], 64'(0));
            check($sformatf("rst_cout_ovf w%0d", wid[i]), {62'd0, gc[i], go[i]}, 64'(0));
        end
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("ready_after_rst w%0d", wid[i]), 64'(ir[i]), 64'(1));
        @(posedge clk); #1;

        for (int k = 0; k < 6; k++) begin
            run_op(1, 64'(tv[k].a), 64'(tv[k].b), tv[k].sub, 0, rs, rc, ro, acc, ok);
            if (ok) begin
                check($sformatf("vec%0d_sum", k), rs, 64'(tv[k].s));
                check($sformatf("vec%0d_cout_ovf", k), {62'd0, rc, ro}, {62'd0, tv[k].c, tv[k].o});
            end
        end

        run_op(1, 64'h5A, 64'h3C, 1'b0, 5, rs, rc, ro, acc, ok);
        if (ok) begin
            check("bp_sum", rs, 64'h96);
            check("bp_cout_ovf", {62'd0, rc, ro}, {62'd0, 1'b0, 1'b1});
        end

        // Reset while bit 3 of 0xAA+0x55 is in flight.
        ga[1] = 64'hAA; gb[1] = 64'h55; gsub[1] = 1'b0; iv[1] = 1'b1; gor[1] = 1'b1;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_ready", 64'(ir[1]), 64'(0));
        check("midrst_valid", 64'(ovl[1]), 64'(0));
        check("midrst_sum", gs[1], 64'(0));
        check("midrst_cout_ovf", {62'd0, gc[1], go[1]}, 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("midrst_ready_release", 64'(ir[1]), 64'(1));
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (ovl[1]) seen = 1'b1;
        end
        check("midrst_no_result", 64'(seen), 64'(0));
        run_op(1, 64'h01, 64'h01, 1'b0, 0, rs, rc, ro, acc, ok);
        if (ok) begin
            check("after_rst_sum", rs, 64'h02);
            check("after_rst_cout_ovf", {62'd0, rc, ro}, 64'(0));
        end

        rand_run(0, 1000);
        rand_run(2, 1000);
        rand_run(1, 200);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
